serial_frame_deserializer: RTL and testbench

Receive-side companion to the team's universal shift register: accepts a bit-serial stream, such as the register's right or left serial output, and assembles it into WIDTH-bit words. Each frame can be LSB-first or MSB-first. Completed words are presented on a valid/ready parallel interface through a one-word output buffer, so the next frame can be collected while the consumer stalls. It sits between a serial link or shift-register chain and a parallel consumer.

---
 rtl/deser_pkg.sv | 6 +
 rtl/deser_shifter.sv | 42 ++++
 rtl/serial_frame_deserializer.sv | 100 ++++++++++
 tb/tb_serial_frame_deserializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// deser_pkg: shared FSM state type and frame direction constants for the deserializer
package deser_pkg;
    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/deser_shifter.sv
// deser_shifter: shift register, bit counter and direction latch; flags the frame's final data bit
module deser_shifter
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             start,
    input  logic             msb_first,
    input  logic             bit_in,
    output logic [WIDTH-1:0] sh,
    output logic [WIDTH-1:0] word_next,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt;
    logic          dir_q;
    logic          dir_eff;
    // the first bit of a frame uses msb_first directly; later bits use the latched direction
    always_comb begin
        dir_eff   = start ? msb_first : dir_q;
        word_next = (dir_eff == DIR_MSB_FIRST) ? {sh[WIDTH-2:0], bit_in} : {bit_in, sh[WIDTH-1:1]};
        last      = shift_en & (cnt == CW'(WIDTH - 1));
    end
    // shift one bit per accepted cycle; the counter wraps to 0 on the final bit or an abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh    <= '0;
            cnt   <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            sh    <= word_next;
            dir_q <= dir_eff;
            cnt   <= last ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer: bit-serial to WIDTH-bit word with one-word valid/ready buffer; DESER_PARITY_EN adds an even-parity bit per frame
module serial_frame_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             msb_first,
    input  logic             frame_abort,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             parity_err
);
`ifdef DESER_PARITY_EN
    localparam state_t FRAME_END = PAR;
`else
    localparam state_t FRAME_END = IDLE;
`endif
    state_t           state;
    state_t           state_nxt;
    logic             shift_en;
    logic             start;
    logic             last;
    logic             complete;
    logic             par_bad;
    logic             drop;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] word;

    deser_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (frame_abort),
        .shift_en  (shift_en),
        .start     (start),
        .msb_first (msb_first),
        .bit_in    (bit_in),
        .sh        (sh),
        .word_next (word_next),
        .last      (last)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: abort wins, gaps hold, final data bit ends the frame or enters PAR
    always_comb begin
        state_nxt = frame_abort      ? IDLE :
                    !bit_valid       ? state :
                    (state == IDLE)  ? RECV :
                    (state == RECV)  ? (last ? FRAME_END : RECV) : IDLE;
    end

    // datapath controls and word completion
    always_comb begin
        start    = (state == IDLE);
        shift_en = bit_valid & ~frame_abort & (state != PAR);
`ifdef DESER_PARITY_EN
        complete = (state == PAR) & bit_valid & ~frame_abort & ~^{sh, bit_in};
        par_bad  = (state == PAR) & bit_valid & ~frame_abort & ^{sh, bit_in};
`else
        complete = last;
        par_bad  = 1'b0;
`endif
        word     = (state == PAR) ? sh : word_next;
        drop     = complete & data_valid & ~data_ready;
    end

    // output buffer, handshake, sticky overrun, parity pulse and busy flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (complete & ~drop) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (data_valid & data_ready) begin
                data_valid <= 1'b0;
            end
            overrun    <= drop | (overrun & ~ovr_clr);
            parity_err <= par_bad;
            busy       <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb_serial_frame_deserializer: directed and randomized checks against a bit-position reference model
module tb_serial_frame_deserializer;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_in = 1'b0;
    logic         msb_first = 1'b0;
    logic         frame_abort = 1'b0;
    logic         data_ready = 1'b0;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic go = 1'b0;

    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_word = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_perr = 1'b0;
    logic         m_par = 1'b0;
    logic         m_dir = 1'b0;
    int           m_cnt = 0;

    serial_frame_deserializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .msb_first   (msb_first),
        .frame_abort (frame_abort),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // reference: place each bit by its index in the frame, deliver or drop whole words
    task automatic model();
        logic got;
        logic perr;
        logic drain;
        got  = 1'b0;
        perr = 1'b0;
        if (!rst_n) begin
            m_data = '0; m_word = '0; m_valid = 0; m_ovr = 0; m_perr = 0; m_par = 0; m_cnt = 0;
            return;
        end
        drain = m_valid & data_ready;
        if (frame_abort) begin
            m_cnt = 0;
            m_par = 0;
        end else if (bit_valid) begin
            if (m_par) begin
                m_par = 0;
                if ((($countones(m_word) + int'(bit_in)) % 2) == 1) perr = 1'b1;
                else got = 1'b1;
            end else begin
                if (m_cnt == 0) begin
                    m_dir  = msb_first;
                    m_word = '0;
                end
                m_word[m_dir ? W - 1 - m_cnt : m_cnt] = bit_in;
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt = 0;
                    if (NB > W) m_par = 1'b1;
                    else got = 1'b1;
                end
            end
        end
        if (got && m_valid && !drain) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
        if (got && (!m_valid || drain)) begin
            m_data  = m_word;
            m_valid = 1'b1;
        end else if (drain) begin
            m_valid = 1'b0;
        end
        m_perr = perr;
    endtask

    task automatic cyc(input logic bv, input logic bi, input logic mf, input logic ab, input logic rd, input logic oc);
        bit_valid = bv; bit_in = bi; msb_first = mf; frame_abort = ab; data_ready = rd; ovr_clr = oc;
        @(posedge clk);
        model();
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] w, input logic mf, input logic tog, input logic rd, input logic rd_last, input logic clr_last);
        for (int i = 0; i < NB; i++) begin
            logic b;
            logic lb;
            b  = (i >= W) ? ^w : (mf ? w[W-1-i] : w[i]);
            lb = (i == NB - 1);
            cyc(1'b1, b, (tog && i > 0) ? ~mf : mf, 1'b0, lb ? rd_last : rd, lb ? clr_last : 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("data_valid", 32'(data_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'((m_cnt != 0) || m_par));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
        end
    end

    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0);
        go = 1'b1;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid_busy_ovr", 32'({data_valid, busy, overrun, parity_err}), 32'h0);
        rst_n = 1'b1;

        send(8'h8D, 0, 0, 1, 1, 0);
        chk("lsb_word", 32'(data_out), 32'h8D);
        chk("lsb_valid", 32'(data_valid), 32'h1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lsb_valid_one_cycle", 32'(data_valid), 32'h0);

        send(8'hB1, 1, 1, 1, 1, 0);
        chk("msb_word_toggle", 32'(data_out), 32'hB1);
        cyc(0, 0, 0, 0, 1, 0);

        send(8'hA5, 0, 0, 0, 0, 0);
        send(8'h3C, 0, 0, 0, 0, 0);
        chk("stall_hold", 32'(data_out), 32'hA5);
        chk("stall_overrun", 32'(overrun), 32'h1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ovr_clr", 32'(overrun), 32'h0);
        send(8'h5A, 0, 0, 0, 0, 1);
        chk("ovr_set_beats_clr", 32'(overrun), 32'h1);
        cyc(0, 0, 0, 0, 1, 1);

        send(8'h01, 0, 0, 0, 0, 0);
        send(8'h02, 0, 0, 0, 1, 0);
        chk("same_edge_valid", 32'(data_valid), 32'h1);
        chk("same_edge_word", 32'(data_out), 32'h02);
        chk("same_edge_no_ovr", 32'(overrun), 32'h0);
        cyc(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 1, 0);
        chk("abort_busy", 32'(busy), 32'h0);
        send(8'hFF, 0, 0, 1, 1, 0);
        chk("after_abort_word", 32'(data_out), 32'hFF);
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("midframe_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        cyc(1, 1, 0, 0, 0, 0);
        chk("midframe_rst_outputs", 32'({data_out, data_valid, busy, overrun, parity_err}), 32'h0);
        rst_n = 1'b1;

`ifdef DESER_PARITY_EN
        send(8'h03, 0, 0, 1, 1, 0);
        chk("par_ok_word", 32'(data_out), 32'h03);
        chk("par_ok_valid", 32'(data_valid), 32'h1);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < W; i++) cyc(1, (i < 3) ? 1'b1 : 1'b0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("par_bad_pulse", 32'(parity_err), 32'h1);
        chk("par_bad_no_valid", 32'(data_valid), 32'h0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("par_bad_one_cycle", 32'(parity_err), 32'h0);
`endif

        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        go = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
